// File: rtl/inst_fetch.sv
// Instruction fetch unit with a direct-mapped instruction cache (one 32-bit word per line).
// Ports: clk/rst/rdy control; iJP_* redirect; iIQ_full / oIQ_* to the instruction queue;
//        oINF_* / iINF_* single-word miss handshake with memctrl.
// Latency: hit emits one edge after pc is set; miss re-looks-up (and hits) one edge after iINF_done.
// Backpressure: iIQ_full stalls IDLE lookups only; an outstanding miss always completes.
module inst_fetch #(
    parameter int INDEX_W = 8,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iJP_en,
    input  logic [ADDR_W-1:0] iJP_pc,
    input  logic              iIQ_full,
    output logic              oIQ_en,
    output logic [31:0]       oIQ_inst,
    output logic [ADDR_W-1:0] oIQ_pc,
    output logic              oINF_en,
    output logic [ADDR_W-1:0] oINF_addr,
    input  logic              iINF_done,
    input  logic [31:0]       iINF_inst
);
    localparam int TAG_W = ADDR_W - INDEX_W - 2;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic {IDLE, MISS} state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] pc;
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [31:0]       data_mem [LINES];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   pc_tag;
    logic               hit;

    // Fill location comes from the request address, not pc: a redirect may
    // have moved pc while the miss was outstanding.
    logic [INDEX_W-1:0] fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               fill;

    logic              pc_nxt_en;
    logic [ADDR_W-1:0] pc_nxt;
    logic              iq_en_nxt;
    logic [31:0]       iq_inst_nxt;
    logic [ADDR_W-1:0] iq_pc_nxt;
    logic              inf_en_nxt;
    logic [ADDR_W-1:0] inf_addr_nxt;

    assign idx      = pc[INDEX_W+1:2];
    assign pc_tag   = pc[ADDR_W-1:INDEX_W+2];
    assign hit      = valid[idx] && (tag_mem[idx] == pc_tag);
    assign fill_idx = oINF_addr[INDEX_W+1:2];
    assign fill_tag = oINF_addr[ADDR_W-1:INDEX_W+2];
    assign fill     = (state == MISS) && iINF_done;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (rdy) begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!iJP_en && !iIQ_full && !hit) state_nxt = MISS;
            MISS: if (iINF_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        pc_nxt_en    = 1'b0;
        pc_nxt       = pc;
        iq_en_nxt    = 1'b0;
        iq_inst_nxt  = oIQ_inst;
        iq_pc_nxt    = oIQ_pc;
        inf_en_nxt   = oINF_en;
        inf_addr_nxt = oINF_addr;
        case (state)
            IDLE: begin
                if (iJP_en) begin
                    pc_nxt_en = 1'b1;
                    pc_nxt    = iJP_pc;
                end else if (iIQ_full) begin
                    pc_nxt_en = 1'b0;
                end else if (hit) begin
                    iq_en_nxt   = 1'b1;
                    iq_inst_nxt = data_mem[idx];
                    iq_pc_nxt   = pc;
                    pc_nxt_en   = 1'b1;
                    pc_nxt      = pc + ADDR_W'(4);
                end else begin
                    inf_en_nxt   = 1'b1;
                    inf_addr_nxt = pc;
                end
            end
            MISS: begin
                // Redirect and fill completion are independent and may coincide.
                if (iINF_done) inf_en_nxt = 1'b0;
                if (iJP_en) begin
                    pc_nxt_en = 1'b1;
                    pc_nxt    = iJP_pc;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and pc; oIQ_en is a pulse and drops while stalled by rdy.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= '0;
            oIQ_en    <= 1'b0;
            oIQ_inst  <= '0;
            oIQ_pc    <= '0;
            oINF_en   <= 1'b0;
            oINF_addr <= '0;
        end else if (rdy) begin
            if (pc_nxt_en) pc <= pc_nxt;
            oIQ_en    <= iq_en_nxt;
            oIQ_inst  <= iq_inst_nxt;
            oIQ_pc    <= iq_pc_nxt;
            oINF_en   <= inf_en_nxt;
            oINF_addr <= inf_addr_nxt;
        end else begin
            oIQ_en <= 1'b0;
        end
    end

    // Valid bits are the only cache state that needs clearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (rdy && fill) begin
            valid[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && fill) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= iINF_inst;
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios with a scoreboard queue
// of expected (pc, inst) pairs consumed by a monitor on every oIQ_en pulse.
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        iJP_en = 1'b0;
    logic [31:0] iJP_pc = '0;
    logic        iIQ_full = 1'b0;
    logic        oIQ_en;
    logic [31:0] oIQ_inst;
    logic [31:0] oIQ_pc;
    logic        oINF_en;
    logic [31:0] oINF_addr;
    logic        iINF_done = 1'b0;
    logic [31:0] iINF_inst = '0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    inst_fetch #(.INDEX_W(8), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .iJP_en    (iJP_en),
        .iJP_pc    (iJP_pc),
        .iIQ_full  (iIQ_full),
        .oIQ_en    (oIQ_en),
        .oIQ_inst  (oIQ_inst),
        .oIQ_pc    (oIQ_pc),
        .oINF_en   (oINF_en),
        .oINF_addr (oINF_addr),
        .iINF_done (iINF_done),
        .iINF_inst (iINF_inst)
    );

    always #5 clk = ~clk;

    // Memory contents: address 0 holds 0x00000513, others a tagged pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0513;
        return {a[23:0], 8'h13};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = mem_word(pc);
        exp_q.push_back(e);
    endtask

    // Monitor: every emitted instruction must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && oIQ_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_emit: got pc %h inst %h expected none", oIQ_pc, oIQ_inst);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (oIQ_pc !== e.pc || oIQ_inst !== e.inst) begin
                    errors++;
                    $display("FAIL emit: got pc %h inst %h expected pc %h inst %h",
                             oIQ_pc, oIQ_inst, e.pc, e.inst);
                end
            end
        end
    end

    task automatic wait_inf(input logic [31:0] a);
        int n;
        n = 0;
        while (!oINF_en && n < 20) begin
            step();
            n++;
        end
        chk("inf_en_rise", {31'b0, oINF_en}, 32'd1);
        chk("inf_addr", oINF_addr, a);
    endtask

    // Serve a miss at address a and let the re-lookup emit it, then stall fetch.
    task automatic miss_fill(input logic [31:0] a);
        iIQ_full = 1'b0;
        wait_inf(a);
        push(a);
        iINF_done = 1'b1;
        iINF_inst = mem_word(a);
        step();
        iINF_done = 1'b0;
        iINF_inst = '0;
        chk("inf_en_drop", {31'b0, oINF_en}, 32'd0);
        step();
        chk("refill_emit", {31'b0, oIQ_en}, 32'd1);
        iIQ_full = 1'b1;
    endtask

    task automatic jump(input logic [31:0] t);
        iJP_en = 1'b1;
        iJP_pc = t;
        step();
        iJP_en = 1'b0;
        iJP_pc = '0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_iq_en",    {31'b0, oIQ_en},  32'd0);
        chk("rst_iq_inst",  oIQ_inst,         32'd0);
        chk("rst_iq_pc",    oIQ_pc,           32'd0);
        chk("rst_inf_en",   {31'b0, oINF_en}, 32'd0);
        chk("rst_inf_addr", oINF_addr,        32'd0);
        rst = 1'b0;

        // 1: cold miss at 0, fill, emit 0x513
        miss_fill(32'h0);

        // 2: prefill 4..C, then stream 0..C from cache
        miss_fill(32'h4);
        miss_fill(32'h8);
        miss_fill(32'hC);
        jump(32'h0);
        for (int i = 0; i < 4; i++) push(32'(i * 4));
        iIQ_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stream_emit", {31'b0, oIQ_en}, 32'd1);
            chk("stream_no_miss", {31'b0, oINF_en}, 32'd0);
        end
        iIQ_full = 1'b1;

        // 3: conflict 0x400 evicts 0x000
        jump(32'h400);
        miss_fill(32'h400);
        jump(32'h0);
        iIQ_full = 1'b0;
        step();
        chk("conflict_miss", {31'b0, oINF_en}, 32'd1);
        miss_fill(32'h0);

        // 4: redirect during miss; fill lands at 0x10 but is not emitted
        jump(32'h10);
        iIQ_full = 1'b0;
        wait_inf(32'h10);
        step();
        jump(32'h80);
        step();
        iINF_done = 1'b1;
        iINF_inst = mem_word(32'h10);
        step();
        iINF_done = 1'b0;
        iINF_inst = '0;
        step();
        miss_fill(32'h80);
        jump(32'h10);
        push(32'h10);
        iIQ_full = 1'b0;
        step();
        chk("redirect_fill_hit", {31'b0, oIQ_en}, 32'd1);
        chk("redirect_fill_no_miss", {31'b0, oINF_en}, 32'd0);
        iIQ_full = 1'b1;

        // 5: hit stream stalled by iIQ_full for 3 cycles
        jump(32'h0);
        push(32'h0);
        push(32'h4);
        iIQ_full = 1'b0;
        step();
        step();
        iIQ_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_stall", {31'b0, oIQ_en}, 32'd0);
        end
        push(32'h8);
        push(32'hC);
        iIQ_full = 1'b0;
        step();
        step();
        iIQ_full = 1'b1;
        step();

        // 6: reset mid-miss, late done ignored, cache empty
        jump(32'h200);
        iIQ_full = 1'b0;
        wait_inf(32'h200);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_miss_inf_en", {31'b0, oINF_en}, 32'd0);
        chk("rst_miss_inf_addr", oINF_addr, 32'd0);
        iIQ_full  = 1'b1;
        iINF_done = 1'b1;
        iINF_inst = 32'hDEAD_BEEF;
        step();
        iINF_done = 1'b0;
        iINF_inst = '0;
        chk("late_done_ignored", {31'b0, oINF_en}, 32'd0);
        iIQ_full = 1'b0;
        step();
        chk("post_rst_miss", {31'b0, oINF_en}, 32'd1);
        chk("post_rst_addr", oINF_addr, 32'd0);
        iIQ_full = 1'b1;
        step();
        step();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
